// File: rtl/photon_reg_port.sv
// Photon-side burst engine for the integer register file: streams N consecutive
// registers out through the photon rs1 port, or in through the photon write port.
module photon_reg_port (
  input  logic        clk,
  input  logic        Rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_base,
  input  logic [5:0]  cmd_count,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        busy,
  output logic        done,
  input  logic [4:0]  core_adr_rs1,
  input  logic        core_wen,
  input  logic [4:0]  core_rd,
  input  logic [31:0] rf_rdata,
  output logic [4:0]  adr_photon_rs1,
  output logic        photon_regwrite,
  output logic [4:0]  addr_corereg_photon,
  output logic [31:0] photon_data_out
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

  state_t              state, state_n;
  logic [IDX_W-1:0]    cur, cur_n;
  logic [CNT_W-1:0]    rem, rem_n;
  logic [DATA_W-1:0]   buf_data_n;
  logic                buf_last_n;
  logic                buf_valid_n;
  logic                done_n;
  logic                grant;
  logic                space;
  logic                pop;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (Rst) begin
      state       <= IDLE;
      cur         <= '0;
      rem         <= '0;
      rdata       <= '0;
      rdata_last  <= 1'b0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      rem         <= rem_n;
      rdata       <= buf_data_n;
      rdata_last  <= buf_last_n;
      rdata_valid <= buf_valid_n;
      done        <= done_n;
    end
  end

  // Next-state, buffer update and port steering
  always_comb begin
    state_n             = state;
    cur_n               = cur;
    rem_n               = rem;
    buf_data_n          = rdata;
    buf_last_n          = rdata_last;
    buf_valid_n         = rdata_valid;
    done_n              = 1'b0;
    cmd_ready           = 1'b0;
    wdata_ready         = 1'b0;
    photon_regwrite     = 1'b0;
    adr_photon_rs1      = '0;
    addr_corereg_photon = cur;
    photon_data_out     = wdata;
    busy                = (state != IDLE);
    grant               = (core_adr_rs1 == '0) || (cur == '0);
    space               = !rdata_valid || rdata_ready;
    pop                 = rdata_valid && rdata_ready;

    if (pop) buf_valid_n = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_n = cmd_base;
          rem_n = cmd_count;
          if (cmd_count == '0) done_n = 1'b1;
          else state_n = cmd_write ? WRITE : READ;
        end
      end
      READ: begin
        adr_photon_rs1 = cur;
        // rf_rdata is only ours when the core is not driving rs1
        if (grant && space) begin
          buf_data_n  = (cur == '0) ? '0 : rf_rdata;
          buf_last_n  = (rem == CNT_W'(1));
          buf_valid_n = 1'b1;
          cur_n       = cur + IDX_W'(1);
          rem_n       = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (pop) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      WRITE: begin
        wdata_ready = !(core_wen && (core_rd == cur) && (cur != '0));
        // x0 words are consumed without a strobe; the photon path does not guard x0
        if (wdata_valid && wdata_ready) begin
          photon_regwrite = (cur != '0);
          cur_n           = cur + IDX_W'(1);
          rem_n           = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_photon_reg_port.sv
// Scoreboarded bench for photon_reg_port: a register-file model, randomized bursts,
// and directed cases for wraparound, core conflicts, x0 handling and mid-burst reset.
module tb_photon_reg_port;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [4:0]  cmd_base = '0;
  logic [5:0]  cmd_count = '0;
  logic        wdata_valid = 1'b0, wdata_ready;
  logic [31:0] wdata = '0;
  logic        rdata_valid, rdata_ready = 1'b0, rdata_last;
  logic [31:0] rdata;
  logic        busy, done;
  logic [4:0]  core_adr_rs1 = '0, core_rd = 5'd1;
  logic        core_wen = 1'b0;
  logic [31:0] core_wdata = '0;
  logic [31:0] rf_rdata;
  logic [4:0]  adr_photon_rs1, addr_corereg_photon;
  logic        photon_regwrite;
  logic [31:0] photon_data_out;

  logic [31:0] rf [32] = '{default: 32'h0};

  int total = 0, bad = 0;
  int cyc = 0, rd_pops = 0, strobe_cnt = 0, done_cnt = 0, exp_done = 0, stall_cnt = 0;
  int rdy_mode = 0, core_mode = 1;
  logic wen_rand = 1'b0, prev_done = 1'b0;
  logic        man_wen = 1'b0;
  logic [4:0]  man_rd = 5'd1, man_adr = '0;
  logic [31:0] man_wdata = '0;

  logic [31:0] rq_dat[$];
  logic        rq_last[$];
  logic [4:0]  wq_adr[$];
  logic [31:0] wq_dat[$];
  logic [31:0] wsrc[$];
  logic [31:0] wbuf[$];

  photon_reg_port dut (
    .clk(clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_base(cmd_base), .cmd_count(cmd_count),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .rdata_last(rdata_last), .busy(busy), .done(done),
    .core_adr_rs1(core_adr_rs1), .core_wen(core_wen), .core_rd(core_rd),
    .rf_rdata(rf_rdata), .adr_photon_rs1(adr_photon_rs1),
    .photon_regwrite(photon_regwrite), .addr_corereg_photon(addr_corereg_photon),
    .photon_data_out(photon_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file environment: core owns rs1 when its address is nonzero
  always @(posedge clk) begin
    if (core_wen) rf[core_rd] <= core_wdata;
    if (photon_regwrite) rf[addr_corereg_photon] <= photon_data_out;
  end
  assign rf_rdata = (core_adr_rs1 != 5'd0) ? rf[core_adr_rs1] : rf[adr_photon_rs1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Background drivers for rdata_ready and the core-side signals
  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0:       rdata_ready = 1'b0;
      1:       rdata_ready = 1'b1;
      default: rdata_ready = 1'($urandom);
    endcase
    if (core_mode == 2) begin
      core_adr_rs1 = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
      core_wen     = wen_rand && ($urandom_range(0, 3) == 0);
      core_rd      = 5'($urandom_range(1, 31));
      core_wdata   = $urandom;
    end else begin
      core_adr_rs1 = man_adr;
      core_wen     = man_wen;
      core_rd      = man_rd;
      core_wdata   = man_wdata;
    end
  end

  // Monitor: pops the scoreboard on every read pop, write strobe and done pulse
  initial forever begin
    @(negedge clk);
    if (Rst) prev_done = 1'b0;
    else begin
      if (rdata_valid && rdata_ready) begin
        rd_pops++;
        if (rq_dat.size() == 0) fail_now("rdata word not expected");
        else begin
          chk("rdata", rdata, rq_dat.pop_front());
          chk("rdata_last", 32'(rdata_last), 32'(rq_last.pop_front()));
        end
      end
      if (photon_regwrite) begin
        strobe_cnt++;
        if (wq_adr.size() == 0) fail_now("photon strobe not expected");
        else begin
          chk("strobe index", 32'(addr_corereg_photon), 32'(wq_adr.pop_front()));
          chk("strobe data", photon_data_out, wq_dat.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (prev_done) fail_now("done held longer than one cycle");
      end
      prev_done = done;
    end
  end

  // Reference: burst i touches register (base+i) mod 32; x0 reads as 0 and is never written
  task automatic prep_cmd(input bit wr, input logic [4:0] base, input logic [5:0] cnt);
    logic [4:0]  idx;
    logic [31:0] w;
    wbuf.delete();
    for (int i = 0; i < int'(cnt); i++) begin
      idx = 5'(int'(base) + i);
      if (wr) begin
        w = (wsrc.size() > 0) ? wsrc.pop_front() : $urandom;
        wbuf.push_back(w);
        if (idx != 5'd0) begin
          wq_adr.push_back(idx);
          wq_dat.push_back(w);
        end
      end else begin
        rq_dat.push_back((idx == 5'd0) ? 32'h0 : rf[idx]);
        rq_last.push_back(i == int'(cnt) - 1);
      end
    end
  endtask

  task automatic issue_cmd(input bit wr, input logic [4:0] base, input logic [5:0] cnt,
                           output bit ok);
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_count = cnt;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) fail_now("command accept timeout");
  endtask

  task automatic write_words(input logic [4:0] base, input logic [5:0] cnt,
                             input int unsigned gap_max);
    logic [4:0] idx;
    bit hs, exp_rdy, rdy;
    for (int i = 0; i < int'(cnt); i++) begin
      idx = 5'(int'(base) + i);
      repeat ($urandom_range(0, gap_max)) begin
        wdata_valid = 1'b0;
        @(posedge clk); #1;
      end
      wdata_valid = 1'b1;
      wdata = wbuf[i];
      hs = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        exp_rdy = !(core_wen && core_rd == idx && idx != 5'd0);
        chk("wdata_ready", 32'(wdata_ready), 32'(exp_rdy));
        chk("photon_regwrite", 32'(photon_regwrite), 32'(exp_rdy && idx != 5'd0));
        rdy = wdata_ready;
        if (!rdy) stall_cnt++;
        @(posedge clk); #1;
        if (rdy) begin hs = 1'b1; break; end
      end
      if (!hs) begin
        fail_now("wdata handshake timeout");
        wdata_valid = 1'b0;
        return;
      end
    end
    wdata_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!busy) begin idle = 1'b1; break; end
    end
    if (!idle) fail_now("burst completion timeout");
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input bit wr, input logic [4:0] base, input logic [5:0] cnt,
                         input int unsigned gap_max, input bit timed);
    int c0;
    bit ok;
    prep_cmd(wr, base, cnt);
    issue_cmd(wr, base, cnt, ok);
    if (!ok) return;
    c0 = cyc;
    if (wr && cnt != 6'd0) write_words(base, cnt, gap_max);
    if (timed) begin
      if (wr && cnt != 6'd0) chk("write burst cycles", 32'(cyc - c0), 32'(cnt));
      @(negedge clk);
      chk("done after last beat", 32'(done), 32'd1);
      chk("busy with done", 32'(busy), 32'd0);
    end
    wait_idle();
    exp_done++;
  endtask

  task automatic core_write(input logic [4:0] r, input logic [31:0] v);
    man_wen = 1'b1; man_rd = r; man_wdata = v;
    @(posedge clk); #1;
    man_wen = 1'b0;
  endtask

  initial begin
    logic [4:0] adr_seq [4];
    int st, target;
    bit ok, wr;
    logic [4:0] base;
    logic [5:0] cnt;

    repeat (3) @(posedge clk);
    #1 Rst = 1'b0;
    @(negedge clk);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rdata_valid", 32'(rdata_valid), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset adr_photon_rs1", 32'(adr_photon_rs1), 32'd0);
    chk("reset photon_regwrite", 32'(photon_regwrite), 32'd0);
    @(posedge clk); #1;

    // Back-to-back writes to x5..x7, then read them back
    rdy_mode = 1;
    wsrc = '{32'hA, 32'hB, 32'hC};
    run_cmd(1'b1, 5'd5, 6'd3, 0, 1'b1);
    chk("x5", rf[5], 32'hA);
    chk("x6", rf[6], 32'hB);
    chk("x7", rf[7], 32'hC);
    run_cmd(1'b0, 5'd5, 6'd3, 0, 1'b0);

    // Wrapping read across x31 -> x0 -> x1
    core_write(5'd30, 32'h1E);
    core_write(5'd31, 32'h1F);
    core_write(5'd1, 32'h11);
    adr_seq[0] = 5'd30; adr_seq[1] = 5'd31; adr_seq[2] = 5'd0; adr_seq[3] = 5'd1;
    fork
      run_cmd(1'b0, 5'd30, 6'd4, 0, 1'b0);
      begin
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("adr_photon_rs1 wrap", 32'(adr_photon_rs1), 32'(adr_seq[k]));
        end
      end
    join

    // Core holds rs1 for the first three read cycles
    core_write(5'd3, 32'h33);
    core_write(5'd4, 32'h44);
    core_write(5'd7, 32'h77);
    man_adr = 5'd7;
    fork
      run_cmd(1'b0, 5'd3, 6'd2, 0, 1'b0);
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("no load while core owns rs1", 32'(rdata_valid), 32'd0);
        end
        @(posedge clk); #1;
        man_adr = 5'd0;
      end
    join

    // Core write-back to x9 blocks the photon write for two cycles
    st = stall_cnt;
    wsrc = '{32'h1234_5678};
    man_wen = 1'b1; man_rd = 5'd9; man_wdata = 32'h999;
    fork
      run_cmd(1'b1, 5'd9, 6'd1, 0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 man_wen = 1'b0;
        @(negedge clk);
        chk("core write to x9 landed", rf[9], 32'h999);
      end
    join
    chk("x9 stall cycles", 32'(stall_cnt - st), 32'd2);
    chk("x9 photon value", rf[9], 32'h1234_5678);

    // x0 is skipped; zero-length command
    wsrc = '{32'hFF, 32'h22};
    run_cmd(1'b1, 5'd0, 6'd2, 0, 1'b0);
    chk("x0 untouched", rf[0], 32'h0);
    chk("x1 written", rf[1], 32'h22);
    st = strobe_cnt;
    run_cmd(1'b1, 5'd12, 6'd0, 0, 1'b1);
    chk("no strobes on count 0", 32'(strobe_cnt - st), 32'd0);

    // Reset after the second popped word of a four-word read
    rdy_mode = 2;
    prep_cmd(1'b0, 5'd10, 6'd4);
    issue_cmd(1'b0, 5'd10, 6'd4, ok);
    target = rd_pops + 2;
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk); #1;
      if (rd_pops >= target) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("read pops before reset timeout");
    @(posedge clk); #1;
    Rst = 1'b1; rdy_mode = 0;
    @(posedge clk); #1;
    Rst = 1'b0;
    rq_dat.delete();
    rq_last.delete();
    @(negedge clk);
    chk("rdata_valid after reset", 32'(rdata_valid), 32'd0);
    chk("busy after reset", 32'(busy), 32'd0);
    repeat (3) begin
      chk("no done after reset", 32'(done), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Randomized bursts with random core traffic and rdata back-pressure
    rdy_mode = 2;
    core_mode = 2;
    for (int k = 0; k < 24; k++) begin
      wr   = 1'($urandom);
      base = 5'($urandom);
      cnt  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 32)) : 6'($urandom_range(1, 6));
      wen_rand = wr;
      run_cmd(wr, base, cnt, 2, 1'b0);
      wen_rand = 1'b0;
      @(posedge clk); #1;
    end
    core_mode = 1;
    repeat (4) @(posedge clk);

    @(negedge clk);
    chk("read scoreboard drained", 32'(rq_dat.size()), 32'd0);
    chk("write scoreboard drained", 32'(wq_adr.size()), 32'd0);
    chk("done pulse count", 32'(done_cnt), 32'(exp_done));
    chk("x0 final", rf[0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    fail_now("global timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "global timeout");
  end

endmodule
